// File: rtl/systolic_mm.sv
// N x N output-stationary systolic matrix multiplier, C = A*B, unsigned operands.
// Define SYSTOLIC_MM_SAT_EN to saturate results to OUT_W bits instead of truncating.
module systolic_mm #(
    parameter int unsigned N     = 3,
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 2 * W + $clog2(N),
    parameter int unsigned OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N*N*W-1:0]       a_flat,
    input  logic [N*N*W-1:0]       b_flat,
    output logic                   busy,
    output logic                   done,
    output logic [N*N*OUT_W-1:0]   c_flat
);
    typedef enum logic [1:0] {StIdle, StCompute, StWrite} state_e;

    localparam int unsigned   TW     = $clog2(3 * N - 1);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    state_e                 r_state;
    logic [TW-1:0]          r_t;
    logic                   r_busy;
    logic                   r_done;
    logic [N*N*OUT_W-1:0]   r_c;
    logic [W-1:0]           r_a   [N][N];
    logic [W-1:0]           r_b   [N][N];
    logic [W-1:0]           r_ah  [N][N];
    logic [W-1:0]           r_bv  [N][N];
    logic [ACC_W-1:0]       r_acc [N][N];

    logic [W-1:0]           w_feed_a [N];
    logic [W-1:0]           w_feed_b [N];
    logic [W-1:0]           w_a_in   [N][N];
    logic [W-1:0]           w_b_in   [N][N];
    logic [N*N*OUT_W-1:0]   w_c;

    // Diagonal skew: row i starts i cycles late, column j starts j cycles late.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_feed_a[i] = '0;
            w_feed_b[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(r_t) == i + k) begin
                    w_feed_a[i] = r_a[i][k];
                    w_feed_b[i] = r_b[k][i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign w_a_in[gi][gj] = w_feed_a[gi];
            end else begin : g_a_pass
                assign w_a_in[gi][gj] = r_ah[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign w_b_in[gi][gj] = w_feed_b[gj];
            end else begin : g_b_pass
                assign w_b_in[gi][gj] = r_bv[gi-1][gj];
            end
        end
    end

`ifdef SYSTOLIC_MM_SAT_EN
    localparam logic [ACC_W:0] SAT_LIM = (ACC_W + 1)'(1) << OUT_W;

    always_comb begin
        w_c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if ({1'b0, r_acc[i][j]} >= SAT_LIM) begin
                    w_c[(i*N+j)*OUT_W +: OUT_W] = {OUT_W{1'b1}};
                end else begin
                    w_c[(i*N+j)*OUT_W +: OUT_W] = r_acc[i][j][OUT_W-1:0];
                end
            end
        end
    end
`else
    always_comb begin
        w_c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_c[(i*N+j)*OUT_W +: OUT_W] = r_acc[i][j][OUT_W-1:0];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_t     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_c     <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a[i][j]   <= '0;
                    r_b[i][j]   <= '0;
                    r_ah[i][j]  <= '0;
                    r_bv[i][j]  <= '0;
                    r_acc[i][j] <= '0;
                end
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++) begin
                                r_a[i][j]   <= a_flat[(i*N+j)*W +: W];
                                r_b[i][j]   <= b_flat[(i*N+j)*W +: W];
                                r_ah[i][j]  <= '0;
                                r_bv[i][j]  <= '0;
                                r_acc[i][j] <= '0;
                            end
                        end
                        r_t     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StCompute;
                    end
                end
                StCompute: begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            r_acc[i][j] <= r_acc[i][j]
                                         + ACC_W'(w_a_in[i][j]) * ACC_W'(w_b_in[i][j]);
                            r_ah[i][j]  <= w_a_in[i][j];
                            r_bv[i][j]  <= w_b_in[i][j];
                        end
                    end
                    r_t <= r_t + TW'(1);
                    if (r_t == T_LAST) begin
                        r_state <= StWrite;
                    end
                end
                StWrite: begin
                    r_c     <= w_c;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign c_flat = r_c;

endmodule

// File: tb/tb_systolic_mm.sv
// Randomized self-checking bench for systolic_mm: a 3x3/W=8 and a 4x4/W=4/OUT_W=10 instance
// checked against a plain sum-of-products model (honours SYSTOLIC_MM_SAT_EN).
module tb_systolic_mm;
    typedef longint unsigned mat_t [4][4];

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start3 = 1'b0;
    logic         start4 = 1'b0;
    logic [71:0]  a3     = '0;
    logic [71:0]  b3     = '0;
    logic [63:0]  a4     = '0;
    logic [63:0]  b4     = '0;
    logic         busy3, done3, busy4, done4;
    logic [71:0]  c3;
    logic [159:0] c4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    systolic_mm #(.N(3), .W(8), .OUT_W(8)) u_dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start3),
        .a_flat (a3),
        .b_flat (b3),
        .busy   (busy3),
        .done   (done3),
        .c_flat (c3)
    );

    systolic_mm #(.N(4), .W(4), .OUT_W(10)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .a_flat (a4),
        .b_flat (b4),
        .busy   (busy4),
        .done   (done4),
        .c_flat (c4)
    );

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] pack(input mat_t m, input int n, input int w);
        logic [159:0] r = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                for (int b = 0; b < w; b++)
                    r[(i*n+j)*w + b] = m[i][j][b];
        return r;
    endfunction

    function automatic longint unsigned elem(input logic [159:0] f, input int i, input int j,
                                             input int n, input int w);
        longint unsigned r = 0;
        for (int b = 0; b < w; b++) r[b] = f[(i*n+j)*w + b];
        return r;
    endfunction

    // Reference: exact dot products, wrapped to the accumulator width, then reduced.
    function automatic void mm_ref(input mat_t a, input mat_t b, input int n, input int accw,
                                   input int outw, output mat_t c);
        longint unsigned s;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) c[i][j] = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += a[i][k] * b[k][j];
                s = s % (64'd1 << accw);
`ifdef SYSTOLIC_MM_SAT_EN
                c[i][j] = (s > (64'd1 << outw) - 1) ? (64'd1 << outw) - 1 : s;
`else
                c[i][j] = s % (64'd1 << outw);
`endif
            end
        end
    endfunction

    function automatic void fill(output mat_t m, input int mode, input int v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                case (mode)
                    0: m[i][j] = longint'(v);
                    1: m[i][j] = (i == j) ? longint'(v) : 0;
                    default: m[i][j] = longint'($urandom_range(0, v));
                endcase
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy4 : busy3;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done4 : done3;
    endfunction

    function automatic logic [159:0] cur_c(input bit sel);
        return sel ? c4 : {88'd0, c3};
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start4 = v;
        else start3 = v;
    endtask

    task automatic scramble();
        logic [159:0] r;
        r  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        a3 = r[71:0];
        b3 = r[143:72];
        a4 = r[63:0];
        b4 = r[127:64];
    endtask

    task automatic start_job(input bit sel, input mat_t a, input mat_t b);
        logic [159:0] pa, pb;
        if (sel) begin
            pa = pack(a, 4, 4);
            pb = pack(b, 4, 4);
            a4 = pa[63:0];
            b4 = pb[63:0];
        end else begin
            pa = pack(a, 3, 8);
            pb = pack(b, 3, 8);
            a3 = pa[71:0];
            b3 = pb[71:0];
        end
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
    endtask

    // mode 1: change operands at cycle 2; mode 2: also pulse start at cycles 3 and 6.
    task automatic wait_done(input bit sel, input int mode, input bit chk_hold,
                             input logic [159:0] hold, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = cur_busy(sel) ? 1 : 0;
        check_eq("busy_after_start", {159'd0, cur_busy(sel)}, 160'd1);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if ((mode == 1 && cyc == 2) || (mode == 2 && cyc == 3)) scramble();
            if (mode == 2 && (cyc == 3 || cyc == 6)) set_start(sel, 1'b1);
            if (mode == 2 && (cyc == 4 || cyc == 7)) set_start(sel, 1'b0);
            check_eq("done_busy_excl", {159'd0, cur_done(sel) & cur_busy(sel)}, 160'd0);
            if (cur_done(sel)) break;
            if (chk_hold) check_eq("c_hold", cur_c(sel), hold);
            if (cur_busy(sel)) bcnt++;
            if (cyc >= 60) begin
                check_eq("done_timeout", 160'd0, 160'd1);
                break;
            end
        end
        set_start(sel, 1'b0);
    endtask

    task automatic check_result(input bit sel, input mat_t e, input string tag);
        int n  = sel ? 4 : 3;
        int ow = sel ? 10 : 8;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                check_eq(tag, 160'(elem(cur_c(sel), i, j, n, ow)), 160'(e[i][j]));
    endtask

    task automatic run_job(input bit sel, input mat_t a, input mat_t b, input int mode,
                           input string tag);
        int   n = sel ? 4 : 3;
        int   cyc, bc;
        mat_t e;
        start_job(sel, a, b);
        wait_done(sel, mode, 1'b0, '0, cyc, bc);
        check_eq({tag, "_latency"}, 160'(cyc), 160'(3 * n - 1));
        check_eq({tag, "_busy_cycles"}, 160'(bc), 160'(3 * n - 1));
        mm_ref(a, b, n, sel ? 10 : 18, sel ? 10 : 8, e);
        check_result(sel, e, tag);
    endtask

    task automatic count_dones(input bit sel, input int cycles, output int nd);
        nd = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (cur_done(sel)) nd++;
        end
    endtask

    initial begin
        mat_t         a, b, e;
        logic [159:0] hold;
        int           cyc, bc, nd;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy3", {159'd0, busy3}, 160'd0);
        check_eq("rst_done3", {159'd0, done3}, 160'd0);
        check_eq("rst_c3", {88'd0, c3}, 160'd0);
        check_eq("rst_busy4", {159'd0, busy4}, 160'd0);
        check_eq("rst_c4", c4, 160'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fill(a, 1, 1);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) b[i][j] = longint'(i * 3 + j + 1);
        run_job(1'b0, a, b, 0, "identity");
        check_eq("identity_c22", 160'(elem(cur_c(0), 2, 2, 3, 8)), 160'd9);

        fill(a, 0, 15);
        fill(b, 0, 15);
        run_job(1'b0, a, b, 0, "all15");
`ifdef SYSTOLIC_MM_SAT_EN
        check_eq("all15_c00", 160'(elem(cur_c(0), 0, 0, 3, 8)), 160'd255);
`else
        check_eq("all15_c00", 160'(elem(cur_c(0), 0, 0, 3, 8)), 160'd163);
`endif

        // Back-to-back: job 2 requested in job 1's done cycle.
        fill(a, 1, 1);
        fill(b, 1, 2);
        run_job(1'b0, a, b, 1, "b2b_job1");
        hold = cur_c(0);
        fill(a, 0, 1);
        fill(b, 0, 1);
        start_job(1'b0, a, b);
        wait_done(1'b0, 0, 1'b1, hold, cyc, bc);
        check_eq("b2b_job2_latency", 160'(cyc), 160'd8);
        mm_ref(a, b, 3, 18, 8, e);
        check_result(1'b0, e, "b2b_job2");
        check_eq("b2b_job2_c11", 160'(elem(cur_c(0), 1, 1, 3, 8)), 160'd3);

        fill(a, 2, 255);
        fill(b, 2, 255);
        run_job(1'b0, a, b, 2, "ignored_start");
        count_dones(1'b0, 12, nd);
        check_eq("ignored_start_extra_done", 160'(nd), 160'd0);

        // Asynchronous reset during compute cycle t=4.
        fill(a, 2, 255);
        fill(b, 2, 255);
        start_job(1'b0, a, b);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", {159'd0, busy3}, 160'd0);
        check_eq("midrst_done", {159'd0, done3}, 160'd0);
        check_eq("midrst_c", {88'd0, c3}, 160'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(1'b0, 12, nd);
        check_eq("midrst_no_done", 160'(nd), 160'd0);
        run_job(1'b0, a, b, 0, "after_rst");

        for (int r = 0; r < 4; r++) begin
            fill(a, 2, 255);
            fill(b, 2, 255);
            run_job(1'b0, a, b, 0, "rand3");
        end

        fill(a, 0, 15);
        fill(b, 0, 15);
        run_job(1'b1, a, b, 0, "n4_all15");
        check_eq("n4_c33", 160'(elem(cur_c(1), 3, 3, 4, 10)), 160'd900);
        for (int r = 0; r < 2; r++) begin
            fill(a, 2, 15);
            fill(b, 2, 15);
            run_job(1'b1, a, b, 0, "rand4");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
